timer_entry_ctrl: RTL and testbench

Keypad entry and run controller for the microwave-oven timer. It collects decimal key presses into a BCD MM:SS preset and issues the load and count-enable strobes to the downstream cascade of down-counter digits. It observes the chain's all-zero status to finish a cook cycle. It sits directly upstream of the per-digit down counters and drives their `in`, `load` and `enablen` inputs.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/bcd_entry_shift.sv | 37 +++
 rtl/timer_entry_ctrl.sv | 109 ++++++++++
 tb/tb_timer_entry_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the microwave timer: keypad codes, controller states
// and a digit-key classifier.
package timer_pkg;

  localparam int unsigned DEFAULT_DIGITS = 4;

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_STOP  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_digit_key(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_entry_shift.sv
// Nibble-wide shift register that accumulates keypad digits, MSD in the top
// nibble; new digits enter at the bottom and the oldest MSD falls off.
module bcd_entry_shift #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  clr,
  input  logic [3:0]            din,
  output logic [4*DIGITS-1:0]   q
);

  logic [4*DIGITS-1:0] q_next;

  generate
    if (DIGITS == 1) begin : g_single
      assign q_next = din;
    end else begin : g_multi
      assign q_next = {q[4*DIGITS-5:0], din};
    end
  endgenerate

  // Clear wins over shift so a simultaneous request can never leave stale digits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values,
      // which is what makes the shift behave as a register chain.
      q <= q_next;
    end
  end

endmodule

// File: rtl/timer_entry_ctrl.sv
// Keypad entry and run controller: builds the BCD MM:SS preset, then loads and
// enables the downstream down-counter chain until it reports all-zero.
module timer_entry_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  tick,
  input  logic                  zero_in,
  output logic [4*DIGITS-1:0]   preset,
  output logic                  load,
  output logic                  enablen,
  output logic                  running,
  output logic                  done
);

  state_t state, state_next;
  logic   shift_en;
  logic   clr;

  logic key_digit, key_start, key_stop, key_clear;
  logic preset_nz;

  // Codes D..F match none of these decodes, so they fall through as no-ops.
  assign key_digit = key_valid && is_digit_key(key_code);
  assign key_start = key_valid && (key_code == KEY_START);
  assign key_stop  = key_valid && (key_code == KEY_STOP);
  assign key_clear = key_valid && (key_code == KEY_CLEAR);
  assign preset_nz = |preset;

  bcd_entry_shift #(
    .DIGITS(DIGITS)
  ) u_entry (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr      (clr),
    .din      (key_code),
    .q        (preset)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    shift_en   = 1'b0;
    clr        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (key_clear) begin
          clr = 1'b1;
        end else if (key_digit) begin
          shift_en = 1'b1;
        end else if (key_start && preset_nz) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        // CLEAR beats the chain finishing, which beats STOP.
        if (key_clear) begin
          clr        = 1'b1;
          state_next = ST_IDLE;
        end else if (zero_in) begin
          state_next = ST_DONE;
        end else if (key_stop) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (key_clear) begin
          clr        = 1'b1;
          state_next = ST_IDLE;
        end else if (key_start) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        clr        = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign load    = (state == ST_LOAD);
  assign running = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  // Ticks only reach the chain in RUN, so one arriving during LOAD is dropped.
  assign enablen = !((state == ST_RUN) && tick);

endmodule

// File: tb/tb_timer_entry_ctrl.sv
// Directed test of timer_entry_ctrl: entry, load/run, pause, done, clear and
// asynchronous reset behaviour with hand-computed expectations.
module tb_timer_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        tick = 1'b0;
  logic        zero_in = 1'b0;
  logic [15:0] preset;
  logic        load;
  logic        enablen;
  logic        running;
  logic        done;

  int errors = 0;
  int checks = 0;

  timer_entry_ctrl #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .tick      (tick),
    .zero_in   (zero_in),
    .preset    (preset),
    .load      (load),
    .enablen   (enablen),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Presents one key across a single rising edge; returns at the following
  // falling edge, i.e. during the cycle after the key was accepted.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (preset !== 16'h0000) begin errors++; $display("FAIL reset_preset: got %h expected 0000", preset); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", load); end
    checks++; if (enablen !== 1'b1) begin errors++; $display("FAIL reset_enablen: got %b expected 1", enablen); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_entry_start;
    press(4'h1); press(4'h3); press(4'h0);
    checks++; if (preset !== 16'h0130) begin errors++; $display("FAIL entry_preset: got %h expected 0130", preset); end
    press(4'hA);
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL start_load: got %b expected 1", load); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_running_in_load: got %b expected 0", running); end
    tick = 1'b1;
    #1;
    checks++; if (enablen !== 1'b1) begin errors++; $display("FAIL tick_in_load_enablen: got %b expected 1", enablen); end
    tick = 1'b0;
    @(negedge clk);
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL load_one_cycle: got %b expected 0", load); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_after_load: got %b expected 1", running); end
    checks++; if (preset !== 16'h0130) begin errors++; $display("FAIL preset_hold_run: got %h expected 0130", preset); end
  endtask

  task automatic test_run_ticks_pause;
    logic exp_en;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tick = (i % 10 == 9);
      exp_en = (i % 10 != 9);
      #1;
      checks++; if (enablen !== exp_en) begin errors++; $display("FAIL run_enablen[%0d]: got %b expected %b", i, enablen, exp_en); end
    end
    @(negedge clk);
    tick = 1'b0;
    press(4'hB);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b expected 0", running); end
    tick = 1'b1;
    #1;
    checks++; if (enablen !== 1'b1) begin errors++; $display("FAIL pause_tick_enablen: got %b expected 1", enablen); end
    @(negedge clk);
    tick = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_holds: got %b expected 0", running); end
    press(4'h7);
    checks++; if (preset !== 16'h0130) begin errors++; $display("FAIL pause_digit_ignored: got %h expected 0130", preset); end
    press(4'hA);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running: got %b expected 1", running); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL resume_no_load: got %b expected 0", load); end
    @(negedge clk);
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL resume_no_load_late: got %b expected 0", load); end
  endtask

  task automatic test_zero_with_stop;
    @(negedge clk);
    zero_in   = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'hB;
    @(negedge clk);
    zero_in   = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse: got %b expected 1", done); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL zero_running: got %b expected 0", running); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    checks++; if (preset !== 16'h0000) begin errors++; $display("FAIL done_preset_clear: got %h expected 0000", preset); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL done_to_idle: got %b expected 0", running); end
  endtask

  task automatic test_shift_discard;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    checks++; if (preset !== 16'h2345) begin errors++; $display("FAIL shift_discard: got %h expected 2345", preset); end
    press(4'hE);
    press(4'hB);
    checks++; if (preset !== 16'h2345) begin errors++; $display("FAIL idle_ignored_keys: got %h expected 2345", preset); end
  endtask

  task automatic test_start_zero;
    press(4'hC);
    checks++; if (preset !== 16'h0000) begin errors++; $display("FAIL idle_clear: got %h expected 0000", preset); end
    press(4'hA);
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL start_zero_load: got %b expected 0", load); end
    @(negedge clk);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_zero_running: got %b expected 0", running); end
  endtask

  task automatic test_clear_pause;
    press(4'h7);
    press(4'hA);
    @(negedge clk);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL cp_running: got %b expected 1", running); end
    press(4'hB);
    press(4'hC);
    checks++; if (preset !== 16'h0000) begin errors++; $display("FAIL pause_clear_preset: got %h expected 0000", preset); end
    press(4'hA);
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL pause_clear_idle: got %b expected 0", load); end
  endtask

  task automatic test_clear_priority;
    press(4'h5);
    press(4'hA);
    @(negedge clk);
    zero_in   = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'hC;
    @(negedge clk);
    zero_in   = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clear_over_zero_done: got %b expected 0", done); end
    checks++; if (preset !== 16'h0000) begin errors++; $display("FAIL clear_over_zero_preset: got %h expected 0000", preset); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL clear_over_zero_running: got %b expected 0", running); end
  endtask

  task automatic test_async_reset;
    press(4'h4); press(4'h2); press(4'hA);
    @(negedge clk);
    tick = 1'b1;
    #1;
    checks++; if (enablen !== 1'b0) begin errors++; $display("FAIL ar_tick_enablen: got %b expected 0", enablen); end
    #1 rst = 1'b0;
    #1;
    checks++; if (enablen !== 1'b1) begin errors++; $display("FAIL ar_enablen: got %b expected 1", enablen); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ar_running: got %b expected 0", running); end
    checks++; if (preset !== 16'h0000) begin errors++; $display("FAIL ar_preset: got %h expected 0000", preset); end
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    press(4'h5); press(4'h6);
    checks++; if (preset !== 16'h0056) begin errors++; $display("FAIL ar_reentry: got %h expected 0056", preset); end
  endtask

  initial begin
    test_reset();
    test_entry_start();
    test_run_ticks_pause();
    test_zero_with_stop();
    test_shift_discard();
    test_start_zero();
    test_clear_pause();
    test_clear_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
